// File: rtl/key_schedule_ctrl_pkg.sv
// Shared types and defaults for the key schedule controller.
// Holds the FSM state encoding and default slot geometry.
package key_schedule_ctrl_pkg;

    localparam int DEF_NUM_KEYS = 4;
    localparam int DEF_KEY_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Key-slot configuration write channel (valid/ready).
// The master writes keys; the controller is the slave.
interface key_schedule_ctrl_if #(
    parameter int SLOT_W = 2,
    parameter int KEY_W  = 3
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [SLOT_W-1:0] cfg_idx;
    logic [KEY_W-1:0]  cfg_key;

    modport master (
        output cfg_valid,
        output cfg_idx,
        output cfg_key,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_idx,
        input  cfg_key,
        output cfg_ready
    );
endinterface

// File: rtl/key_schedule_ctrl_key_slot_bank.sv
// Key slot register array: one write port, one combinational read.
// Cleared to zero on reset so stale keys never leak after a reset.
module key_slot_bank #(
    parameter int NUM_KEYS = 4,
    parameter int KEY_W    = 3,
    parameter int SLOT_W   = $clog2(NUM_KEYS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_idx,
    input  logic [KEY_W-1:0]  wr_key,
    input  logic [SLOT_W-1:0] rd_idx,
    output logic [KEY_W-1:0]  rd_key
);
    logic [KEY_W-1:0] mem [NUM_KEYS];

    // Store a key into the addressed slot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_idx] <= wr_key;
        end
    end

    assign rd_key = mem[rd_idx];
endmodule

// File: rtl/key_schedule_ctrl.sv
// Time-multiplexed key schedule controller for a locked datapath.
// Steps through loaded key slots, one per cycle, with pause/stop.
module key_schedule_ctrl
    import key_schedule_ctrl_pkg::*;
#(
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int KEY_W    = DEF_KEY_W,
    parameter int SLOT_W   = $clog2(NUM_KEYS)
) (
    input  logic              clock,
    input  logic              reset,
    key_schedule_ctrl_if.slave cfg,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    output logic [KEY_W-1:0]  active_key,
    output logic [SLOT_W-1:0] slot_idx,
    output logic              key_valid,
    output logic              busy,
    output logic              err
);
    state_t            state;
    state_t            state_nxt;
    logic [SLOT_W-1:0] slot_nxt;
    logic              err_nxt;
    logic [NUM_KEYS-1:0] loaded;
    logic              all_loaded;
    logic              wr_en;
    logic [KEY_W-1:0]  rd_key;

    assign cfg.cfg_ready = (state == IDLE);
    assign wr_en         = cfg.cfg_valid & cfg.cfg_ready;
    assign all_loaded    = &loaded;
    assign busy          = (state != IDLE);
    assign key_valid     = busy;

    // The bank is read at the next slot so active_key can be registered
    // yet line up with slot_idx in the same cycle.
    key_slot_bank #(
        .NUM_KEYS (NUM_KEYS),
        .KEY_W    (KEY_W),
        .SLOT_W   (SLOT_W)
    ) u_bank (
        .clock  (clock),
        .reset  (reset),
        .wr_en  (wr_en),
        .wr_idx (cfg.cfg_idx),
        .wr_key (cfg.cfg_key),
        .rd_idx (slot_nxt),
        .rd_key (rd_key)
    );

    // Next state, next slot and error pulse; stop beats start and pause.
    always_comb begin
        state_nxt = state;
        slot_nxt  = slot_idx;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                slot_nxt = '0;
                if (start && !stop) begin
                    if (all_loaded) begin
                        state_nxt = RUN;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            RUN, PAUSE: begin
                if (stop) begin
                    state_nxt = IDLE;
                    slot_nxt  = '0;
                end else if (pause) begin
                    state_nxt = PAUSE;
                end else begin
                    state_nxt = RUN;
                    slot_nxt  = slot_idx + SLOT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                slot_nxt  = '0;
            end
        endcase
    end

    // FSM, slot counter, registered key and error pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            slot_idx   <= '0;
            active_key <= '0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            slot_idx   <= slot_nxt;
            active_key <= (state_nxt != IDLE) ? rd_key : '0;
            err        <= err_nxt;
        end
    end

    // Loaded mask: one bit per slot, set on an accepted write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            loaded <= '0;
        end else if (wr_en) begin
            loaded[cfg.cfg_idx] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Directed scoreboard bench for key_schedule_ctrl.
// Expected outputs are queued per step and compared after each edge.
module tb_key_schedule_ctrl;

    typedef struct packed {
        logic [2:0] key;
        logic [1:0] slot;
        logic       busy;
        logic       err;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic [2:0] active_key;
    logic [1:0] slot_idx;
    logic       key_valid;
    logic       busy;
    logic       err;

    int vectors;
    int miscompares;
    exp_t sb_q[$];

    key_schedule_ctrl_if #(.SLOT_W(2), .KEY_W(3)) cfg_bus ();

    key_schedule_ctrl #(
        .NUM_KEYS (4),
        .KEY_W    (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cfg        (cfg_bus.slave),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .active_key (active_key),
        .slot_idx   (slot_idx),
        .key_valid  (key_valid),
        .busy       (busy),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_now(input string tag);
        check({tag, "_key"},   8'(active_key), 8'h0);
        check({tag, "_slot"},  8'(slot_idx),   8'h0);
        check({tag, "_valid"}, 8'(key_valid),  8'h0);
        check({tag, "_busy"},  8'(busy),       8'h0);
        check({tag, "_err"},   8'(err),        8'h0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input string tag, input logic [2:0] k,
                        input logic [1:0] s, input logic b,
                        input logic e);
        exp_t x;
        x.key  = k;
        x.slot = s;
        x.busy = b;
        x.err  = e;
        sb_q.push_back(x);
        tick();
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            x = sb_q.pop_front();
            check({tag, "_key"},   8'(active_key), 8'(x.key));
            check({tag, "_slot"},  8'(slot_idx),   8'(x.slot));
            check({tag, "_busy"},  8'(busy),       8'(x.busy));
            check({tag, "_valid"}, 8'(key_valid),  8'(x.busy));
            check({tag, "_err"},   8'(err),        8'(x.err));
        end
    endtask

    task automatic write_slot(input logic [1:0] idx, input logic [2:0] k);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_idx   = idx;
        cfg_bus.cfg_key   = k;
        step("load", 3'd0, 2'd0, 1'b0, 1'b0);
        cfg_bus.cfg_valid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        pause       = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_idx   = '0;
        cfg_bus.cfg_key   = '0;
        #2;
        check_idle_now("rst");
        check("rst_ready", 8'(cfg_bus.cfg_ready), 8'h1);
        #10;
        reset = 1'b0;
        tick();

        // Load 5,2,7,1 and run one full pass plus wrap.
        write_slot(2'd0, 3'd5);
        write_slot(2'd1, 3'd2);
        write_slot(2'd2, 3'd7);
        write_slot(2'd3, 3'd1);
        start = 1'b1;
        step("run0", 3'd5, 2'd0, 1'b1, 1'b0);
        start = 1'b0;
        check("run_ready", 8'(cfg_bus.cfg_ready), 8'h0);
        step("run1", 3'd2, 2'd1, 1'b1, 1'b0);
        step("run2", 3'd7, 2'd2, 1'b1, 1'b0);
        step("run3", 3'd1, 2'd3, 1'b1, 1'b0);
        step("wrap", 3'd5, 2'd0, 1'b1, 1'b0);
        step("run1b", 3'd2, 2'd1, 1'b1, 1'b0);
        step("run2b", 3'd7, 2'd2, 1'b1, 1'b0);

        // Pause at slot 2 for three cycles, then resume.
        pause = 1'b1;
        step("pause0", 3'd7, 2'd2, 1'b1, 1'b0);
        step("pause1", 3'd7, 2'd2, 1'b1, 1'b0);
        step("pause2", 3'd7, 2'd2, 1'b1, 1'b0);
        pause = 1'b0;
        step("resume0", 3'd1, 2'd3, 1'b1, 1'b0);
        step("resume1", 3'd5, 2'd0, 1'b1, 1'b0);

        // Write attempt while running must be refused.
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_idx   = 2'd1;
        cfg_bus.cfg_key   = 3'd6;
        #1;
        check("busy_ready", 8'(cfg_bus.cfg_ready), 8'h0);
        step("nowrite", 3'd2, 2'd1, 1'b1, 1'b0);
        cfg_bus.cfg_valid = 1'b0;

        // start+stop together resolves to stop.
        start = 1'b1;
        stop  = 1'b1;
        step("ststop", 3'd0, 2'd0, 1'b0, 1'b0);
        start = 1'b0;
        stop  = 1'b0;
        check("idle_ready", 8'(cfg_bus.cfg_ready), 8'h1);
        start = 1'b1;
        step("restart0", 3'd5, 2'd0, 1'b1, 1'b0);
        start = 1'b0;
        step("restart1", 3'd2, 2'd1, 1'b1, 1'b0);

        // start while busy is ignored.
        start = 1'b1;
        step("busystart", 3'd7, 2'd2, 1'b1, 1'b0);
        start = 1'b0;

        // stop+pause together resolves to stop.
        pause = 1'b1;
        stop  = 1'b1;
        step("pstop", 3'd0, 2'd0, 1'b0, 1'b0);
        pause = 1'b0;
        stop  = 1'b0;
        start = 1'b1;
        step("again0", 3'd5, 2'd0, 1'b1, 1'b0);
        start = 1'b0;
        step("again1", 3'd2, 2'd1, 1'b1, 1'b0);

        // Asynchronous reset mid-run.
        #2;
        reset = 1'b1;
        #1;
        check_idle_now("arst");
        tick();
        reset = 1'b0;
        start = 1'b1;
        step("rst_err", 3'd0, 2'd0, 1'b0, 1'b1);
        start = 1'b0;
        step("rst_err_end", 3'd0, 2'd0, 1'b0, 1'b0);

        // Partial load: start must be rejected.
        write_slot(2'd0, 3'd3);
        write_slot(2'd1, 3'd6);
        write_slot(2'd2, 3'd0);
        start = 1'b1;
        step("part_err", 3'd0, 2'd0, 1'b0, 1'b1);
        start = 1'b0;
        check("part_ready", 8'(cfg_bus.cfg_ready), 8'h1);
        step("part_end", 3'd0, 2'd0, 1'b0, 1'b0);

        // Complete the load and run through the wrap with new keys.
        write_slot(2'd3, 3'd4);
        start = 1'b1;
        step("new0", 3'd3, 2'd0, 1'b1, 1'b0);
        start = 1'b0;
        step("new1", 3'd6, 2'd1, 1'b1, 1'b0);
        step("new2", 3'd0, 2'd2, 1'b1, 1'b0);
        step("new3", 3'd4, 2'd3, 1'b1, 1'b0);
        step("newwrap", 3'd3, 2'd0, 1'b1, 1'b0);
        stop = 1'b1;
        step("final", 3'd0, 2'd0, 1'b0, 1'b0);
        stop = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/key_schedule_ctrl.md
KEY_SCHEDULE_CTRL -- requirements
Module: key_schedule_ctrl

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of key slots; SHALL be a power of two, 2..16.
REQ-002 Parameter KEY_W, default 3: width of each key slot in bits.
REQ-003 Parameter SLOT_W, default $clog2(NUM_KEYS): slot index width.
REQ-004 clock  in  1  single clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 cfg_valid  in  1  key-slot write request.
REQ-007 cfg_ready  out  1  write accepted when cfg_valid & cfg_ready are both high on a rising edge.
REQ-008 cfg_idx  in  SLOT_W  slot to write.
REQ-009 cfg_key  in  KEY_W  key value to write.
REQ-010 start  in  1  begin the time-multiplexed key schedule.
REQ-011 stop  in  1  abort the schedule and return to idle.
REQ-012 pause  in  1  freeze the slot counter while running.
REQ-013 active_key  out  KEY_W  key driven to the locked datapath's key inputs.
REQ-014 slot_idx  out  SLOT_W  current schedule slot; equivalent to the datapath's count state.
REQ-015 key_valid  out  1  high when active_key is meaningful.
REQ-016 busy  out  1  high in RUN or PAUSE.
REQ-017 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and PAUSE.
REQ-019 cfg_ready SHALL be 1 only in IDLE; an accepted write SHALL store cfg_key in slot cfg_idx and set loaded[cfg_idx].
REQ-020 cfg_valid outside IDLE SHALL be ignored, with no stored or mask change.
REQ-021 In IDLE, start with loaded all-ones SHALL move the FSM to RUN with slot_idx=0 on the next edge.
REQ-022 In IDLE, start with any loaded bit clear SHALL pulse err for exactly one cycle and leave the FSM in IDLE.
REQ-023 In RUN with pause low, slot_idx SHALL increment by 1 each cycle and wrap from NUM_KEYS-1 to 0.
REQ-024 In RUN, pause high SHALL move the FSM to PAUSE with slot_idx held; pause low in PAUSE SHALL return to RUN, and counting SHALL resume on the next edge.
REQ-025 active_key SHALL be registered and equal key_mem[slot_idx] in the same cycle; total latency from start to key_mem[0] valid is 1 cycle.
REQ-026 key_valid SHALL equal busy; in IDLE, active_key and slot_idx SHALL be 0.
REQ-027 stop in RUN or PAUSE SHALL return the FSM to IDLE and zero slot_idx on the next edge.
REQ-028 start and stop high together SHALL resolve to stop; start while busy SHALL be ignored.
REQ-029 stop and pause high together SHALL resolve to stop.
REQ-030 Key slots and the loaded mask SHALL persist across start/stop cycles.

Reset
REQ-031 reset SHALL asynchronously force IDLE and clear slot_idx, active_key, key_valid, busy, err, loaded and all key slots to 0.
REQ-032 reset asserted mid-RUN SHALL drop key_valid immediately (asynchronously); after deassertion, start SHALL err until all slots are reloaded.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/RUN/PAUSE) and the default NUM_KEYS/KEY_W constants.
REQ-034 The key store SHALL be one sub-module, key_slot_bank: a register array with write port and combinational read port.

Verification
REQ-035 Load slots 0..3 = 5,2,7,1; pulse start -> active_key sequence 5,2,7,1,5 over 5 cycles, slot_idx 0,1,2,3,0.
REQ-036 Load only slots 0..2; pulse start -> err high for 1 cycle; busy stays 0; cfg_ready stays 1.
REQ-037 Running at slot 2; hold pause for 3 cycles -> active_key stays 7 and slot_idx stays 2; after release -> 1, then 5.
REQ-038 Running; assert start and stop together -> next cycle IDLE, key_valid=0, slot_idx=0; keys retained and restart gives 5 first.
REQ-039 Running; cfg_valid with idx 1, key 6 -> cfg_ready=0 and the slot-1 key remains 2 on the next pass.
REQ-040 Assert reset mid-RUN -> outputs 0 at once; then start -> err pulse.
